// File: rtl/mult_div_unit_if.sv
`default_nettype none
// mult_div_unit_if: request/result bundle between a requester and mult_div_unit; rev 1.0
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  ALU_Control;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, ALU_Control, A, B,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, ALU_Control, A, B,
    output busy, done, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// mult_div_unit: 32-bit signed MULT (shift-add) / DIV (restoring), 32 iterations each; rev 1.0
// Define MULTDIV_SINGLE_CYCLE_MUL_EN to compute MULT combinationally with a one-cycle result.
module mult_div_unit (
  input  logic           clk,
  input  logic           reset_n,
  mult_div_unit_if.slave mdu
);

  localparam logic [3:0] OP_MULT = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [5:0] ITERS   = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [63:0] work_q;
  logic [31:0] opnd_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
`ifdef MULTDIV_SINGLE_CYCLE_MUL_EN
  logic        pend_q;
  logic [63:0] prod_full_d;
`endif

  logic        is_mult_d;
  logic        is_div_d;
  logic        start_ok_d;
  logic [31:0] mag_a_d;
  logic [31:0] mag_b_d;

  assign is_mult_d  = (mdu.ALU_Control == OP_MULT);
  assign is_div_d   = (mdu.ALU_Control == OP_DIV);
  assign start_ok_d = mdu.start && (is_mult_d || is_div_d);
  assign mag_a_d    = mdu.A[31] ? (~mdu.A + 32'd1) : mdu.A;
  assign mag_b_d    = mdu.B[31] ? (~mdu.B + 32'd1) : mdu.B;

`ifdef MULTDIV_SINGLE_CYCLE_MUL_EN
  assign prod_full_d = {32'd0, mag_a_d} * {32'd0, mag_b_d};
`endif

  // MULT: multiplier sits in work_q[31:0], partial product accumulates in work_q[63:32].
  logic [32:0] mul_sum_d;
  logic [63:0] mul_step_d;
  assign mul_sum_d  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_step_d = {mul_sum_d, work_q[31:1]};

  // DIV: remainder in work_q[63:32], dividend shifts out of work_q[31:0] as quotient shifts in.
  logic [32:0] rem_sh_d;
  logic        rem_ge_d;
  logic [31:0] rem_sub_d;
  logic [63:0] div_step_d;
  assign rem_sh_d   = {work_q[63:32], work_q[31]};
  assign rem_ge_d   = (rem_sh_d >= {1'b0, opnd_q});
  assign rem_sub_d  = rem_sh_d[31:0] - opnd_q;
  assign div_step_d = {(rem_ge_d ? rem_sub_d : rem_sh_d[31:0]), work_q[30:0], rem_ge_d};

  logic        neg_res_d;
  logic [63:0] prod_fix_d;
  logic [31:0] quot_fix_d;
  logic [31:0] rem_fix_d;
  logic [31:0] a_orig_d;
  assign neg_res_d  = sign_a_q ^ sign_b_q;
  assign prod_fix_d = neg_res_d ? (~work_q + 64'd1) : work_q;
  assign quot_fix_d = neg_res_d ? (~work_q[31:0] + 32'd1) : work_q[31:0];
  assign rem_fix_d  = sign_a_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];
  assign a_orig_d   = sign_a_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULTDIV_SINGLE_CYCLE_MUL_EN
      pend_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
`ifdef MULTDIV_SINGLE_CYCLE_MUL_EN
          if (pend_q) begin
            pend_q  <= 1'b0;
            hi_q    <= prod_fix_d[63:32];
            lo_q    <= prod_fix_d[31:0];
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else
`endif
          if (start_ok_d) begin
            cnt_q    <= '0;
            sign_a_q <= mdu.A[31];
            sign_b_q <= mdu.B[31];
            if (is_div_d) begin
              work_q  <= {32'd0, mag_a_d};
              opnd_q  <= mag_b_d;
              state_q <= S_DIV;
              // A zero divisor finishes on the next edge, so it never reports busy.
              busy_q  <= (mag_b_d != 32'd0);
            end else begin
`ifdef MULTDIV_SINGLE_CYCLE_MUL_EN
              work_q  <= prod_full_d;
              opnd_q  <= mag_a_d;
              pend_q  <= 1'b1;
`else
              work_q  <= {32'd0, mag_b_d};
              opnd_q  <= mag_a_d;
              state_q <= S_MUL;
              busy_q  <= 1'b1;
`endif
            end
          end
        end

        S_MUL: begin
          if (cnt_q == ITERS) begin
            hi_q    <= prod_fix_d[63:32];
            lo_q    <= prod_fix_d[31:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            work_q <= mul_step_d;
            cnt_q  <= cnt_q + 6'd1;
          end
        end

        S_DIV: begin
          if (opnd_q == 32'd0) begin
            hi_q    <= a_orig_d;
            lo_q    <= 32'hFFFF_FFFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (cnt_q == ITERS) begin
            hi_q    <= rem_fix_d;
            lo_q    <= quot_fix_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            work_q <= div_step_d;
            cnt_q  <= cnt_q + 6'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.busy = busy_q;
  assign mdu.done = done_q;
  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// tb_mult_div_unit: scoreboard bench for mult_div_unit with directed MULT/DIV vectors; rev 1.0
module tb_mult_div_unit;

  localparam logic [3:0] OP_MULT = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b1011;
`ifdef MULTDIV_SINGLE_CYCLE_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic clk = 1'b0;
  logic reset_n;

  mult_div_unit_if mdu ();

  mult_div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mdu     (mdu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   op_id = 0;
  logic prev_done = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && mdu.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 HI=%h LO=%h, required no completion", mdu.HI, mdu.LO);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("op%0d_HI", mon_e.id), mdu.HI, mon_e.hi);
        check($sformatf("op%0d_LO", mon_e.id), mdu.LO, mon_e.lo);
      end
      check("done_one_cycle", 32'(prev_done), 32'd0);
    end
    prev_done <= mdu.done;
  end

  task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat, input int inj_at);
    int k;
    bit saw_busy;
    op_id++;
    sb_q.push_back('{hi: ehi, lo: elo, id: op_id});
    mdu.start       = 1'b1;
    mdu.ALU_Control = ctrl;
    mdu.A           = a;
    mdu.B           = b;
    @(posedge clk); #1;
    mdu.start = 1'b0;
    check($sformatf("op%0d_busy_after_E0", op_id), 32'(mdu.busy), (lat > 1) ? 32'd1 : 32'd0);
    k = 0;
    saw_busy = 1'b0;
    while (mdu.done !== 1'b1 && k < 100) begin
      if (inj_at != 0 && k == inj_at - 1) begin
        mdu.start = 1'b1;
        mdu.A     = 32'd9;
      end
      @(posedge clk); #1;
      mdu.start = 1'b0;
      k++;
      if (mdu.busy === 1'b1) saw_busy = 1'b1;
    end
    check($sformatf("op%0d_latency", op_id), 32'(k), 32'(lat));
    if (lat == 1) check($sformatf("op%0d_busy_never", op_id), 32'(saw_busy), 32'd0);
  endtask

  initial begin
    int dn;
    reset_n         = 1'b0;
    mdu.start       = 1'b0;
    mdu.ALU_Control = 4'd0;
    mdu.A           = 32'd0;
    mdu.B           = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(mdu.busy), 32'd0);
    check("reset_done", 32'(mdu.done), 32'd0);
    check("reset_HI", mdu.HI, 32'd0);
    check("reset_LO", mdu.LO, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(OP_MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, 0);
    run_op(OP_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
    run_op(OP_DIV,  32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, 1, 0);
    run_op(OP_MULT, 32'd3,          32'd4,         32'd0,         32'd12,        MUL_LAT, 5);
    run_op(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33, 0);
    run_op(OP_DIV,  32'd100,        32'd7,         32'd2,         32'd14,        33, 0);
    run_op(OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33, 0);
    run_op(OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         33, 0);
    run_op(OP_MULT, 32'h8000_0000,  32'd2,         32'hFFFF_FFFF, 32'd0,         MUL_LAT, 0);
    run_op(OP_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1,         MUL_LAT, 0);
    run_op(OP_MULT, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'd1,         MUL_LAT, 0);
    run_op(OP_MULT, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0,         MUL_LAT, 0);
    run_op(OP_DIV,  32'h8000_0000,  32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    run_op(OP_MULT, 32'd0,          32'd12345,     32'd0,         32'd0,         MUL_LAT, 0);

    // Unsupported operation code: no completion, results untouched.
    mdu.start       = 1'b1;
    mdu.ALU_Control = 4'b0000;
    mdu.A           = 32'd77;
    mdu.B           = 32'd11;
    @(posedge clk); #1;
    mdu.start = 1'b0;
    check("badop_busy", 32'(mdu.busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("badop_HI_held", mdu.HI, 32'd0);
    check("badop_LO_held", mdu.LO, 32'd0);

    // Load nonzero results so the reset clearing is observable.
    run_op(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0);

    // Reset during a DIV at E10.
    mdu.start       = 1'b1;
    mdu.ALU_Control = OP_DIV;
    mdu.A           = 32'd1000;
    mdu.B           = 32'd3;
    @(posedge clk); #1;
    mdu.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy_before_reset", 32'(mdu.busy), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_busy", 32'(mdu.busy), 32'd0);
    check("midreset_done", 32'(mdu.done), 32'd0);
    check("midreset_HI", mdu.HI, 32'd0);
    check("midreset_LO", mdu.LO, 32'd0);
    reset_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mdu.done === 1'b1) dn++;
    end
    check("midreset_no_done", 32'(dn), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: operation request, sampled each rising edge.
REQ-004 SHALL have port ALU_Control, input, 4 bits: operation select; 4'b0101 = signed multiply (MULT), 4'b1011 = signed divide (DIV).
REQ-005 SHALL have port A, input, 32 bits: multiplicand or dividend.
REQ-006 SHALL have port B, input, 32 bits: multiplier or divisor.
REQ-007 SHALL have port busy, output, 1 bit: operation in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port HI, output, 32 bits: product upper word or remainder.
REQ-010 SHALL have port LO, output, 32 bits: product lower word or quotient.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV and DONE; busy=1 only in MUL or DIV, and done=1 only in DONE.
REQ-012 SHALL, in IDLE or DONE, accept start=1 with ALU_Control of 0101 or 1011 at edge E0, latch operand magnitudes and result signs, clear the iteration counter, and enter MUL or DIV.
REQ-013 SHALL ignore start when ALU_Control is any other code, staying in or returning to IDLE.
REQ-014 SHALL ignore start while busy=1, leaving operands and the in-flight operation untouched.
REQ-015 SHALL perform MUL as a 32-iteration shift-add over operand magnitudes on edges E1..E32, producing a 64-bit product.
REQ-016 SHALL perform DIV as a 32-iteration restoring division over operand magnitudes on edges E1..E32.
REQ-017 SHALL, at edge E33, apply sign fixup, update HI/LO, and enter DONE; done=1 for exactly that one cycle.
REQ-018 SHALL set the MUL result to the two's-complement 64-bit product, with HI = bits 63:32 and LO = bits 31:0.
REQ-019 SHALL set the DIV quotient (LO) truncated toward zero and the remainder (HI) to the sign of the dividend.
REQ-020 SHALL, on DIV with B=0, skip iteration, set HI=A and LO=32'hFFFFFFFF at E1, and enter DONE.
REQ-021 SHALL, on DIV of 32'h80000000 by 32'hFFFFFFFF, produce LO=32'h80000000 and HI=0 with no exception.
REQ-022 SHALL hold HI/LO stable except at result write or reset.
REQ-023 SHALL leave DONE to IDLE on the next edge unless a new valid start is accepted, enabling back-to-back operations.

Reset
REQ-024 SHALL, on reset_n=0 at any rising edge, enter IDLE with busy=0, done=0, HI=0, LO=0, and counter=0.
REQ-025 SHALL, on reset mid-operation, discard the in-flight operation with no done pulse.
REQ-026 SHALL give reset priority over start on the same edge.

Configuration
REQ-027 SHALL, when macro MULTDIV_SINGLE_CYCLE_MUL_EN is defined, compute MUL combinationally at E0, write HI/LO at E1, and assert done after E1, with MUL state unused and busy never asserted for MUL.
REQ-028 SHALL, when MULTDIV_SINGLE_CYCLE_MUL_EN is undefined, use the iterative MUL of REQ-015; DIV behaviour is identical in both builds.

Verification
REQ-029 SHALL cover MULT with A=7 and B=32'hFFFFFFFD (-3) -> after E33, HI=32'hFFFFFFFF, LO=32'hFFFFFFEB, and done high for one cycle.
REQ-030 SHALL cover DIV with A=32'hFFFFFFF9 (-7) and B=2 -> after E33, LO=32'hFFFFFFFD and HI=32'hFFFFFFFF.
REQ-031 SHALL cover DIV with A=5 and B=0 -> after E1, HI=5, LO=32'hFFFFFFFF, and done=1, with busy never high.
REQ-032 SHALL cover MULT with A=3 and B=4, a second start at E5 with A=9 -> after E33, LO=12 and HI=0, with the second start ignored.
REQ-033 SHALL cover a DIV started, then reset_n=0 at E10 -> next cycle busy=0, done=0, and HI=LO=0, with no done pulse thereafter.
REQ-034 SHALL cover, with MULTDIV_SINGLE_CYCLE_MUL_EN, MULT with A=32'h80000000 and B=2 -> after E1, HI=32'hFFFFFFFF, LO=0, and done=1.
